// File: rtl/score_bcd_draw_pkg.sv
// Shared definitions for the score_bcd_draw block.
//   state_t    - conversion FSM state encoding
//   RGB_W      - width of an RGB444 colour word
//   sat_limit  - 10^digits, the first value that no longer fits the display
package score_bcd_draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int RGB_W = 12;

    function automatic logic [31:0] sat_limit(input int digits);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 32'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/score_bcd_draw_segment.sv
// Seven-segment glyph hit test for one digit cell.
// The glyph is 10 px wide and 19 px tall, 2 px strokes, origin (OX, OY) at top-left.
// Ports:
//   x, y    - current pixel coordinate
//   digit   - BCD digit to draw (10..15 draw nothing)
//   enable  - 0 suppresses the whole cell (leading-zero blanking)
//   hit     - pixel lies on a lit segment of this cell
module score_bcd_draw_segment #(
    parameter int OX = 0,
    parameter int OY = 0
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [3:0] digit,
    input  logic       enable,
    output logic       hit
);

    // bit order {g, f, e, d, c, b, a}
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic in_box(input logic [10:0] px, input logic [10:0] py,
                                    input int x0, input int x1, input int y0, input int y1);
        return (px >= 11'(OX + x0)) && (px <= 11'(OX + x1)) &&
               (py >= 11'(OY + y0)) && (py <= 11'(OY + y1));
    endfunction

    logic [10:0] px;
    logic [10:0] py;
    logic [6:0]  on_seg;

    assign px = {1'b0, x};
    assign py = {1'b0, y};

    always_comb begin
        on_seg    = '0;
        on_seg[0] = in_box(px, py, 0, 9, 0, 1);     // a
        on_seg[1] = in_box(px, py, 8, 9, 0, 9);     // b
        on_seg[2] = in_box(px, py, 8, 9, 9, 18);    // c
        on_seg[3] = in_box(px, py, 0, 9, 17, 18);   // d
        on_seg[4] = in_box(px, py, 0, 1, 9, 18);    // e
        on_seg[5] = in_box(px, py, 0, 1, 0, 9);     // f
        on_seg[6] = in_box(px, py, 0, 9, 8, 9);     // g
    end

    assign hit = enable && |(on_seg & seg_pattern(digit));

endmodule

// File: rtl/score_bcd_draw.sv
// Draws a binary score as DIGITS seven-segment decimal digits.
// The score is converted to BCD with a bit-serial double dabble, held in a
// pending buffer and committed to the display only at a frame boundary.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   x, y        - current pixel coordinate
//   score       - unsigned binary score
//   frame_tick  - one-cycle pulse at frame start
//   flash       - one-cycle pulse starting a FLASH_FRAMES blink
//   isScore     - pixel is on a lit, visible segment (combinational in x, y)
//   score_rgb   - constant lit-pixel colour
//   busy        - conversion in progress
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | display up to date; waiting for a score change
// ST_CONVERT | shifting one score bit per cycle into the BCD register
// ST_HOLD    | result in pending buffer, waiting for frame_tick to commit
module score_bcd_draw
    import score_bcd_draw_pkg::*;
#(
    parameter int          DIGITS       = 4,
    parameter int          SCORE_W      = 14,
    parameter int          X0           = 490,
    parameter int          Y0           = 20,
    parameter int          PITCH        = 15,
    parameter logic [11:0] COLOR        = 12'h888,
    parameter bit          BLANK_LZ     = 1'b1,
    parameter int          FLASH_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [SCORE_W-1:0] score,
    input  logic               frame_tick,
    input  logic               flash,
    output logic               isScore,
    output logic [RGB_W-1:0]   score_rgb,
    output logic               busy
);

    localparam int          BCD_W     = DIGITS * 4;
    localparam int          CNT_W     = $clog2(SCORE_W);
    localparam int          FL_RAW    = $clog2(FLASH_FRAMES + 1);
    localparam int          FL_W      = (FL_RAW > 4) ? FL_RAW : 4;
    localparam logic [31:0] SAT_LIMIT = sat_limit(DIGITS);
    localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

    state_t             state, state_nxt;
    logic [SCORE_W-1:0] score_q, last_conv, bin_sr;
    logic [BCD_W-1:0]   bcd, bcd_adj, bcd_shift, result, pend_bcd, disp_bcd, commit_val;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sat, pend_flag, changed, start, commit;
    logic [FL_W-1:0]    flash_cnt;
    logic               blink;
    logic [DIGITS-1:0]  vis, hits;
    logic               seen;

    assign changed   = (score_q != last_conv);
    assign busy      = (state == ST_CONVERT);
    assign score_rgb = COLOR;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            bcd_adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
        end
    end

    assign bcd_shift  = {bcd_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
    assign result     = sat ? NINES : bcd_shift;
    // A commit straight out of CONVERT takes the result being formed this cycle.
    assign commit_val = (state == ST_CONVERT) ? result : pend_bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (changed || pend_flag) begin
                    start     = 1'b1;
                    state_nxt = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bit_cnt == '0) begin
                    if (frame_tick) begin
                        commit    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q   <= '0;
            last_conv <= '0;
            bin_sr    <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            sat       <= 1'b0;
            pend_flag <= 1'b0;
            pend_bcd  <= '0;
            disp_bcd  <= '0;
        end else begin
            score_q <= score;
            if (start) begin
                last_conv <= score_q;
                bin_sr    <= score_q;
                bcd       <= '0;
                bit_cnt   <= CNT_W'(SCORE_W - 1);
                sat       <= (32'(score_q) >= SAT_LIMIT);
                pend_flag <= 1'b0;
            end else begin
                if (state == ST_CONVERT) begin
                    bcd     <= bcd_shift;
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) pend_bcd <= result;
                end
                if (state != ST_IDLE && changed) pend_flag <= 1'b1;
            end
            if (commit) disp_bcd <= commit_val;
        end
    end

    // flash takes priority over the per-frame decrement so a repeat request restarts the blink
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
        end else if (flash) begin
            flash_cnt <= FL_W'(FLASH_FRAMES);
        end else if (frame_tick && flash_cnt != '0) begin
            flash_cnt <= flash_cnt - 1'b1;
        end
    end

    assign blink = (flash_cnt != '0) && flash_cnt[3];

    // Cell i = 0 is the most significant digit; it lives in the top nibble of disp_bcd.
    always_comb begin
        seen = 1'b0;
        vis  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seen   = seen | (disp_bcd[(DIGITS-1-i)*4 +: 4] != 4'd0);
            vis[i] = seen || (i == DIGITS - 1) || !BLANK_LZ;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        score_bcd_draw_segment #(
            .OX(X0 + i * PITCH),
            .OY(Y0)
        ) u_segment (
            .x     (x),
            .y     (y),
            .digit (disp_bcd[(DIGITS-1-i)*4 +: 4]),
            .enable(vis[i]),
            .hit   (hits[i])
        );
    end

    assign isScore = (|hits) && !blink;

endmodule

// File: tb/tb_score_bcd_draw.sv
module tb_score_bcd_draw;

    localparam int X0 = 490;
    localparam int Y0 = 20;
    localparam int PITCH = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [13:0] score = '0;
    logic        frame_tick = 1'b0;
    logic        flash = 1'b0;
    logic        isScore;
    logic [11:0] score_rgb;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // probe point per segment a..g, relative to the digit origin
    int px [7] = '{4, 9, 9, 4, 0, 0, 4};
    int py [7] = '{0, 4, 13, 18, 13, 4, 8};
    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        int          value;
        logic [15:0] expect_code;
        bit          exact;
    } vec_t;
    vec_t vecs [11];

    logic [15:0] cur_disp;

    always #5 clk = ~clk;

    score_bcd_draw dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .score     (score),
        .frame_tick(frame_tick),
        .flash     (flash),
        .isScore   (isScore),
        .score_rgb (score_rgb),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Display as 4 nibbles, MSD first: digit value, F = blank cell, E = unreadable glyph.
    task automatic read_display(output logic [15:0] code);
        logic [6:0] pat;
        logic [3:0] nib;
        code = '0;
        for (int i = 0; i < 4; i++) begin
            pat = '0;
            for (int k = 0; k < 7; k++) begin
                x = 10'(X0 + i * PITCH + px[k]);
                y = 10'(Y0 + py[k]);
                #1;
                pat[k] = isScore;
            end
            nib = 4'hE;
            if (pat == 7'h00) nib = 4'hF;
            for (int d = 0; d < 10; d++) if (glyph[d] == pat) nib = 4'(d);
            code[(3-i)*4 +: 4] = nib;
        end
    endtask

    function automatic logic [15:0] model_code(input int v);
        int s, p, d;
        bit lead;
        logic [15:0] code;
        s = (v > 9999) ? 9999 : v;
        lead = 1'b1;
        code = '0;
        p = 1000;
        for (int i = 0; i < 4; i++) begin
            d = (s / p) % 10;
            if (lead && d == 0 && i != 3) begin
                code[(3-i)*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
                code[(3-i)*4 +: 4] = 4'(d);
            end
            p = p / 10;
        end
        return code;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    // exact=1 raises frame_tick in the very cycle the last bit is shifted in.
    task automatic run_score(input string name, input int v, input logic [15:0] exp, input bit exact);
        int nb;
        logic [15:0] got;
        nb = 0;
        @(posedge clk); #1;
        score = 14'(v);
        if (exact) begin
            repeat (15) begin
                @(posedge clk); #1;
                nb += int'(busy);
            end
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            check({name, " busy_after_commit"}, int'(busy), 0);
        end else begin
            repeat (20) begin
                @(posedge clk); #1;
                nb += int'(busy);
            end
            read_display(got);
            check({name, " held_before_tick"}, int'(got), int'(cur_disp));
            tick();
        end
        check({name, " busy_cycles"}, nb, 14);
        read_display(got);
        check({name, " display"}, int'(got), int'(exp));
        cur_disp = exp;
    endtask

    initial begin
        logic [15:0] got;
        int v, prev, rem;
        bit exp_on;

        vecs[0]  = '{1234,  16'h1234, 1'b0};
        vecs[1]  = '{7,     16'hFFF7, 1'b1};
        vecs[2]  = '{12345, 16'h9999, 1'b0};
        vecs[3]  = '{0,     16'hFFF0, 1'b1};
        vecs[4]  = '{9999,  16'h9999, 1'b0};
        vecs[5]  = '{10000, 16'h9999, 1'b1};
        vecs[6]  = '{1000,  16'h1000, 1'b0};
        vecs[7]  = '{305,   16'hF305, 1'b1};
        vecs[8]  = '{16383, 16'h9999, 1'b0};
        vecs[9]  = '{99,    16'hFF99, 1'b1};
        vecs[10] = '{8,     16'hFFF8, 1'b0};

        // reset state
        #12;
        check("reset busy", int'(busy), 0);
        check("reset rgb", int'(score_rgb), 12'h888);
        read_display(got);
        check("reset display", int'(got), 16'hFFF0);
        cur_disp = 16'hFFF0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle after reset busy", int'(busy), 0);

        for (int i = 0; i < 11; i++) begin
            run_score($sformatf("vec%0d", i), vecs[i].value, vecs[i].expect_code, vecs[i].exact);
        end
        check("rgb after run", int'(score_rgb), 12'h888);

        // change during conversion: 10 shown first, 20 only after a further tick
        @(posedge clk); #1;
        score = 14'd10;
        repeat (5) @(posedge clk);
        #1;
        score = 14'd20;
        repeat (30) @(posedge clk);
        #1;
        read_display(got);
        check("midconv no tick", int'(got), int'(cur_disp));
        tick();
        read_display(got);
        check("midconv first commit", int'(got), 16'hFF10);
        repeat (30) @(posedge clk);
        #1;
        read_display(got);
        check("midconv held", int'(got), 16'hFF10);
        tick();
        read_display(got);
        check("midconv second commit", int'(got), 16'hFF20);
        cur_disp = 16'hFF20;

        // random scores against the arithmetic model
        prev = 20;
        for (int n = 0; n < 12; n++) begin
            v = int'($urandom_range(0, 16383));
            if (n % 3 == 0) v = int'($urandom_range(0, 999));
            if (v == prev) v = v ^ 1;
            run_score($sformatf("rand%0d(%0d)", n, v), v, model_code(v), bit'(n % 2));
            prev = v;
        end

        // reset in the middle of a conversion
        @(posedge clk); #1;
        score = 14'd5000;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("reset midconv busy", int'(busy), 0);
        read_display(got);
        check("reset midconv display", int'(got), 16'hFFF0);
        score = 14'd42;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tick();
        read_display(got);
        check("after reset 42", int'(got), 16'hFF42);

        // blink: probe segment a of the units digit ('2' lights a)
        @(posedge clk); #1;
        flash = 1'b1;
        @(posedge clk); #1;
        flash = 1'b0;
        rem = 64;
        for (int k = 0; k < 72; k++) begin
            if (k == 20) begin
                @(posedge clk); #1;
                flash = 1'b1;
                @(posedge clk); #1;
                flash = 1'b0;
                rem = 64;
            end
            x = 10'(X0 + 3 * PITCH + 4);
            y = 10'(Y0);
            #1;
            exp_on = !(rem != 0 && ((rem / 8) % 2 == 1));
            check($sformatf("blink frame %0d", k), int'(isScore), int'(exp_on));
            tick();
            if (rem > 0) rem--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_bcd_draw.md
SCORE_BCD_DRAW -- requirements
Module: score_bcd_draw

Interface
REQ-001 Parameter DIGITS, default 4: number of decimal digits drawn (1..8).
REQ-002 Parameter SCORE_W, default 14: score input width in bits (4..32).
REQ-003 Parameter X0, default 490: x of the most-significant digit's segment origin.
REQ-004 Parameter Y0, default 20: y of all digit segment origins.
REQ-005 Parameter PITCH, default 15: x spacing between adjacent digits, in pixels.
REQ-006 Parameter COLOR, default 12'h888: RGB444 colour of lit pixels.
REQ-007 Parameter BLANK_LZ, default 1: 1 = blank leading zeros; 0 = draw all digits.
REQ-008 Parameter FLASH_FRAMES, default 64: blink duration after a flash request, in frames.
REQ-009 clk  input  1  system/pixel clock; all state on rising edge.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 x, y  input  10 each  current pixel coordinate.
REQ-012 score  input  SCORE_W  binary score, unsigned.
REQ-013 frame_tick  input  1  one-cycle pulse at frame start (vertical blank).
REQ-014 flash  input  1  one-cycle pulse requesting blink (e.g. new high score).
REQ-015 isScore  output  1  current pixel lies on a lit, visible segment.
REQ-016 score_rgb  output  12  COLOR, constant.
REQ-017 busy  output  1  binary-to-BCD conversion in progress.

Function
REQ-018 Change detect: score registered each cycle; score differing from last converted value starts a conversion on the next cycle if idle.
REQ-019 Conversion is sequential shift-add-3 (double dabble): one input bit per cycle, exactly SCORE_W cycles, busy high throughout.
REQ-020 FSM states IDLE, CONVERT, HOLD; IDLE->CONVERT on change; CONVERT->HOLD after SCORE_W shifts; HOLD->IDLE on commit.
REQ-021 Saturation: captured score >= 10^DIGITS converts as all nines (e.g. DIGITS=4, 12345 -> 9999).
REQ-022 Result sits in a pending buffer; displayed digits update only on frame_tick while in HOLD (no mid-frame tearing).
REQ-023 frame_tick in the same cycle conversion completes: new digits commit that cycle.
REQ-024 Score change during CONVERT/HOLD: set pending flag; after commit, restart with the newest score; intermediate values may be skipped.
REQ-025 Digit i (0 = MSD) drawn at (X0 + i*PITCH, Y0) with the existing seven-segment glyph geometry.
REQ-026 BLANK_LZ=1: digits above the most significant nonzero digit are not drawn; units digit always drawn (score 0 -> "0").
REQ-027 flash loads flash_cnt with FLASH_FRAMES; flash_cnt decrements on each frame_tick to 0; flash while nonzero reloads.
REQ-028 isScore forced 0 while flash_cnt != 0 and flash_cnt[3] == 1 (8-frame on/off blink).
REQ-029 isScore combinational from x, y, displayed digits, blink state; zero added latency vs. x, y.

Reset
REQ-030 rst_n low: FSM IDLE, busy 0, displayed digits all 0, pending flag 0, flash_cnt 0, last-converted value 0.
REQ-031 Reset mid-conversion abandons it; after release, a nonzero score triggers a fresh conversion.
REQ-032 score_rgb = COLOR in and out of reset; isScore during reset reflects displayed digits of 0.

Structure
REQ-033 Shared package/header holds FSM state encodings, RGB444 width, and the 10^DIGITS saturation-limit function.
REQ-034 One sub-module, segment (existing seven-segment glyph hit test), instantiated DIGITS times via generate.
REQ-035 Binary-to-BCD datapath and FSM stay in score_bcd_draw; no further sub-modules.

Verification
REQ-036 Reset, score=1234, frame_tick after 14+ cycles -> busy high exactly 14 cycles; digits 1,2,3,4 after tick; pixel on MSD segment -> isScore 1.
REQ-037 score=7, BLANK_LZ=1 -> only units digit drawn; pixels in thousands/hundreds/tens cells -> isScore 0.
REQ-038 score=12345, DIGITS=4 -> digits display 9,9,9,9.
REQ-039 score 10 -> 20 mid-conversion -> 10 committed at next tick, 20 converted and committed at following tick; no tick -> display unchanged.
REQ-040 flash pulse, FLASH_FRAMES=64 -> isScore suppressed in frames where flash_cnt[3]=1, normal after 64 ticks.
REQ-041 rst_n low mid-conversion -> busy 0 immediately, digits 0; release with score=42 -> "42" after next tick.
